// File: rtl/result_display.sv
// Seven-segment display back end: iterative shift-add-3 binary-to-BCD conversion
// of the arithmetic result, with leading-zero blanking and an "Err" override.
module result_display #(
  parameter int width = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*width-1:0]   value,
  input  logic                 err,
  output logic [6:0]           hex0,
  output logic [6:0]           hex1,
  output logic [6:0]           hex2,
  output logic [6:0]           hex3,
  output logic                 busy
);

  localparam int W2 = 2 * width;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              err_s_q, err_s_d;
  logic [W2-1:0]     value_s_q, value_s_d;
  logic              dirty_q, dirty_d;
  logic [W2-1:0]     shift_q, shift_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [15:0]       bcd_adj;
  logic [3:0]        cnt_q, cnt_d;
  logic [6:0]        hex0_q, hex0_d;
  logic [6:0]        hex1_q, hex1_d;
  logic [6:0]        hex2_q, hex2_d;
  logic [6:0]        hex3_q, hex3_d;
  logic [3:0]        d0, d1, d2, d3;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction on every nibble that would overflow a decimal digit when doubled
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  assign d0 = bcd_q[3:0];
  assign d1 = bcd_q[7:4];
  assign d2 = bcd_q[11:8];
  assign d3 = bcd_q[15:12];

  always_comb begin
    state_d   = state_q;
    err_s_d   = err_s_q;
    value_s_d = value_s_q;
    dirty_d   = dirty_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    hex0_d    = hex0_q;
    hex1_d    = hex1_q;
    hex2_d    = hex2_q;
    hex3_d    = hex3_q;

    case (state_q)
      IDLE: begin
        if (dirty_q || ({err, value} != {err_s_q, value_s_q})) begin
          err_s_d   = err;
          value_s_d = value;
          shift_d   = value;
          bcd_d     = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        bcd_d   = {bcd_adj[14:0], shift_q[W2-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'(W2 - 1))
          state_d = DONE;
      end

      DONE: begin
        dirty_d = 1'b0;
        state_d = IDLE;
        if (err_s_q) begin
          hex3_d = 7'h06;
          hex2_d = 7'h2F;
          hex1_d = 7'h2F;
          hex0_d = SEG_BLANK;
        end else begin
          // Blank leading zeros; the ones digit always shows
          hex0_d = seg7(d0);
          hex1_d = (d3 == 4'd0 && d2 == 4'd0 && d1 == 4'd0) ? SEG_BLANK : seg7(d1);
          hex2_d = (d3 == 4'd0 && d2 == 4'd0) ? SEG_BLANK : seg7(d2);
          hex3_d = (d3 == 4'd0) ? SEG_BLANK : seg7(d3);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      err_s_q   <= 1'b0;
      value_s_q <= '0;
      dirty_q   <= 1'b1;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      hex0_q    <= SEG_BLANK;
      hex1_q    <= SEG_BLANK;
      hex2_q    <= SEG_BLANK;
      hex3_q    <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      err_s_q   <= err_s_d;
      value_s_q <= value_s_d;
      dirty_q   <= dirty_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      hex0_q    <= hex0_d;
      hex1_q    <= hex1_d;
      hex2_q    <= hex2_d;
      hex3_q    <= hex3_d;
    end
  end

  assign hex0 = hex0_q;
  assign hex1 = hex1_q;
  assign hex2 = hex2_q;
  assign hex3 = hex3_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display (width = 6, 13-cycle latency).
module tb_result_display;

  logic        clk;
  logic        rst_n;
  logic [11:0] value;
  logic        err;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        busy;

  int checks = 0;
  int errors = 0;

  result_display #(.width(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .value(value),
    .err  (err),
    .hex0 (hex0),
    .hex1 (hex1),
    .hex2 (hex2),
    .hex3 (hex3),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkDisplay(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    checkOutput({tag, ".hex3"}, {25'd0, hex3}, {25'd0, e3});
    checkOutput({tag, ".hex2"}, {25'd0, hex2}, {25'd0, e2});
    checkOutput({tag, ".hex1"}, {25'd0, hex1}, {25'd0, e1});
    checkOutput({tag, ".hex0"}, {25'd0, hex0}, {25'd0, e0});
  endtask

  task automatic applyStimulus(input logic [11:0] v, input logic e);
    value = v;
    err   = e;
  endtask

  // Counts negedges with busy high until it drops again, bounded at 40 cycles
  task automatic measureConversion(output int busyCycles);
    busyCycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      else if (busyCycles > 0) break;
    end
  endtask

  task automatic runConversion(input string tag, input logic [11:0] v, input logic e,
                               input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
    int n;
    applyStimulus(v, e);
    measureConversion(n);
    checkOutput({tag, ".busyCycles"}, n, 13);
    checkOutput({tag, ".busyDone"}, {31'd0, busy}, 32'd0);
    checkDisplay(tag, e3, e2, e1, e0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    applyStimulus(12'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkDisplay("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);

    rst_n = 1'b1;
    repeat (13) @(negedge clk);
    checkOutput("release.busyN13", {31'd0, busy}, 32'd1);
    checkOutput("release.noGlitch", {25'd0, hex0}, 32'h7F);
    @(negedge clk);
    checkOutput("release.busyN14", {31'd0, busy}, 32'd0);
    checkDisplay("release", 7'h7F, 7'h7F, 7'h7F, 7'h40);

    repeat (5) @(negedge clk);
    checkOutput("idle.noReconvert", {31'd0, busy}, 32'd0);

    runConversion("v4095", 12'd4095, 1'b0, 7'h19, 7'h40, 7'h10, 7'h12);
    runConversion("v105",  12'd105,  1'b0, 7'h7F, 7'h79, 7'h40, 7'h12);
    runConversion("v1000", 12'd1000, 1'b0, 7'h79, 7'h40, 7'h40, 7'h40);
    runConversion("v10",   12'd10,   1'b0, 7'h7F, 7'h7F, 7'h79, 7'h40);
    runConversion("err",   12'd10,   1'b1, 7'h06, 7'h2F, 7'h2F, 7'h7F);
    runConversion("err2",  12'd4095, 1'b1, 7'h06, 7'h2F, 7'h2F, 7'h7F);

    applyStimulus(12'd7, 1'b0);
    repeat (5) @(negedge clk);
    applyStimulus(12'd3969, 1'b0);
    repeat (9) @(negedge clk);
    checkOutput("mid.busyDone", {31'd0, busy}, 32'd0);
    checkDisplay("mid.first", 7'h7F, 7'h7F, 7'h7F, 7'h78);
    @(negedge clk);
    checkOutput("mid.restart", {31'd0, busy}, 32'd1);
    repeat (13) @(negedge clk);
    checkOutput("mid.busyDone2", {31'd0, busy}, 32'd0);
    checkDisplay("mid.second", 7'h30, 7'h10, 7'h02, 7'h10);

    applyStimulus(12'd4095, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("rst.inShift", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkDisplay("rst.async", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    checkOutput("rst.asyncBusy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    measureConversion(n);
    checkOutput("rst.busyCycles", n, 13);
    checkDisplay("rst.after", 7'h19, 7'h40, 7'h10, 7'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_display.md
# result_display

Display back end for the calculator datapath. Consumes the `2*width`-bit unsigned result and the error flag produced by the arithmetic top level and drives four active-low seven-segment displays. Binary-to-BCD conversion is iterative (shift-add-3, one bit per cycle) under a small FSM, and the displays hold the last completed conversion. An error condition replaces the number with "Err".

## Interface

- `width`, default 6: operand width of the arithmetic stage. The result input is `2*width` bits. Supported range is 1..6, so the result is at most 12 bits and four decimal digits.

- `clk`  in  1  sole clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `value`  in  2*width  unsigned result from the arithmetic stage; may change on any cycle
- `err`  in  1  overflow/error flag from the arithmetic stage
- `hex0`  out  7  ones digit, segments {g,f,e,d,c,b,a}, active-low, registered
- `hex1`  out  7  tens digit, same encoding
- `hex2`  out  7  hundreds digit, same encoding
- `hex3`  out  7  thousands digit, same encoding
- `busy`  out  1  high while a conversion is in progress (state ≠ IDLE)

## Operation

- **State held:**
  - Shadow `{err_s, value_s}`: the inputs last accepted.
  - `dirty` flag.
  - Binary shift register, `2*width` bits.
  - 16-bit BCD register.
  - Bit counter.
- **Reset** (asynchronous while `rst_n`=0):
  - State = IDLE.
  - `hex0..hex3` = 7'h7F (blank), `busy`=0.
  - Shadow = 0, BCD = 0, counter = 0.
  - `dirty`=1, which forces one conversion after release.
- **FSM states:** IDLE, SHIFT, DONE.
  - **IDLE:** if `dirty`, or `{err,value}` ≠ shadow, then:
    - Copy the inputs into the shadow and the shift register.
    - Clear BCD and the counter.
    - Go to SHIFT.
    - Otherwise remain in IDLE.
  - **SHIFT:** once per cycle:
    - Every BCD nibble ≥5 first gets +3.
    - Then `{bcd, shift}` shifts left by 1.
    - Counter +1.
    - After the `2*width`-th shift, go to DONE.
  - **DONE:**
    - Register the display outputs and clear `dirty`.
    - Go to IDLE.
- **Display mapping in DONE:**
  - **Error case** (`err_s`=1): `hex3`=7'h06 ("E"), `hex2`=7'h2F ("r"), `hex1`=7'h2F, `hex0`=7'h7F. The BCD result is ignored. Error conversions take the same path and have the same latency.
  - **Normal case:** each nibble is encoded 0..9 as 40,79,24,30,19,12,02,78,00,10 (hex). Nibble values above 9 cannot occur.
  - **Leading-zero blanking:** `hex3` is blank if d3=0; `hex2` is blank if d3=d2=0; `hex1` is blank if d3=d2=d1=0. `hex0` is never blanked.
- **Inputs changing during SHIFT/DONE** are not sampled. On return to IDLE the next compare against the shadow detects the change and starts a new conversion. No input change is lost as long as it is held.
- **Widths:**
  - The BCD register is always 16 bits.
  - For `width` < 6, the upper digits are naturally zero and blanked.
  - The add-3 correction is applied to all four nibbles.

## Timing

- Edge E0: IDLE accepts the inputs; `busy` is 1 after E0.
- Edges E1..E(2*width): shifts.
- Edge E(2*width+1): DONE registers `hex0..hex3`; `busy` is 0 after this edge.
- Input-to-display latency is `2*width+1` cycles from acceptance. For `width`=6 this is 13 cycles.
- `hex*` change only at the DONE edge or at reset, so there are no intermediate glitches.
- Back-to-back conversions: the earliest re-acceptance is the edge after DONE, so the minimum period is `2*width+2` cycles.
- Reset mid-conversion: the outputs blank immediately (asynchronously). The conversion restarts from IDLE after release because `dirty`=1.

## Test plan

- **Reset release** with `value`=0, `err`=0:
  - `hex*`=7F and `busy`=0 during reset.
  - 13 cycles after the first post-reset edge: `hex0`=40, `hex1..hex3`=7F, `busy`=0.
- **`value`=4095:**
  - Display after 13 cycles: `hex3`=19, `hex2`=40, `hex1`=10, `hex0`=12 ("4095").
  - `busy` is high for exactly 13 cycles.
- **`value`=105:**
  - `hex3`=7F, `hex2`=79, `hex1`=40, `hex0`=12.
  - The interior zero is displayed, not blanked.
- **`err`=1** with any value: `hex3`=06, `hex2`=2F, `hex1`=2F, `hex0`=7F, after the same 13-cycle latency.
- **Change mid-conversion:**
  - Apply `value` 7 → 3969 at cycle 5 of the 7 conversion.
  - The display shows "7" at DONE.
  - A second conversion starts on the next edge and shows 3969 (`hex3`=30, `hex2`=10, `hex1`=02, `hex0`=10).
- **Assert `rst_n`=0** during SHIFT: `hex*`=7F and `busy`=0 immediately, and a full conversion follows release.
